// File: rtl/alu_pkg.sv
// Shared encodings for the serial add/subtract datapath.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple adder built from fadder cells; also exposes the carry into its MSB.
module chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum_c,
    output logic             cout_c,
    output logic             cmsb_c
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        fadder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .ci   (c[i]),
            .s_c  (sum_c[i]),
            .co_c (c[i+1])
        );
    end

    assign cout_c = c[CHUNK];
    assign cmsb_c = c[CHUNK-1];

endmodule

// File: rtl/fadder.sv
// Single-bit full adder cell.
module fadder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s_c,
    output logic co_c
);

    assign s_c  = a ^ b ^ ci;
    assign co_c = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: processes one CHUNK-bit slice of the operands per clock.
module serial_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

    state_t            state, state_d;
    logic              load, fin;
    logic [WIDTH-1:0]  a_q, b_q, acc_q, acc_d;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic [CHUNK-1:0]  sum_c;
    logic              cout_c, cmsb_c;
    logic              last_c;

    assign last_c = (idx_q == IDXW'(N - 1));

    chunk_adder #(.CHUNK(CHUNK)) u_add (
        .a      (a_q[CHUNK*idx_q +: CHUNK]),
        .b      (b_q[CHUNK*idx_q +: CHUNK]),
        .cin    (carry_q),
        .sum_c  (sum_c),
        .cout_c (cout_c),
        .cmsb_c (cmsb_c)
    );

    // Accumulator with the current chunk's sum merged into its slot.
    always_comb begin
        acc_d = acc_q;
        acc_d[CHUNK*idx_q +: CHUNK] = sum_c;
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_c) begin
                    fin     = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            state <= state_d;
            busy  <= (state_d == RUN);
            done  <= (state_d == DONE);
            if (load) begin
                // Subtraction as a + ~b + 1: invert b once and seed the carry.
                a_q     <= a;
                b_q     <= b ^ {WIDTH{op == OP_SUB}};
                carry_q <= (op == OP_SUB);
                idx_q   <= '0;
                acc_q   <= '0;
            end else if (state == RUN) begin
                acc_q   <= acc_d;
                carry_q <= cout_c;
                idx_q   <= idx_q + IDXW'(1);
                if (fin) begin
                    result   <= acc_d;
                    cout     <= cout_c;
                    overflow <= cmsb_c ^ cout_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (32-bit/8-bit main instance plus a single-chunk instance).
module tb_serial_addsub;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CHUNK = 8;
    localparam int unsigned N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             reset, start, op;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, cout, overflow;
    logic [WIDTH-1:0] result;
    logic             busy1, done1, cout1, overflow1;
    logic [WIDTH-1:0] result1;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
    } exp_t;

    exp_t             sbq[$];
    exp_t             mon_e;
    int               checks   = 0;
    int               errors   = 0;
    int               done_cnt = 0;
    logic [WIDTH-1:0] last_r   = '0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
    );

    serial_addsub #(.WIDTH(WIDTH), .CHUNK(WIDTH)) dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy1), .done(done1), .result(result1), .cout(cout1), .overflow(overflow1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %0h expected no completion", result);
            end else begin
                mon_e = sbq.pop_front();
                chk("result",   64'(result),   64'(mon_e.r));
                chk("cout",     64'(cout),     64'(mon_e.c));
                chk("overflow", 64'(overflow), 64'(mon_e.v));
            end
        end
    end

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] er,
                          input logic ec, input logic ev);
        int lat;
        lat = -1;
        op = o; a = x; b = y; start = 1'b1;
        sbq.push_back('{er, ec, ev});
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_busy"}, 64'(busy), 64'(1));
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                chk({name, "_hold"}, 64'(result), 64'(last_r));
                chk({name, "_n1"}, {30'd0, done1, cout1, result1}, {30'd0, 1'b1, ec, er});
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        chk({name, "_lat"}, 64'(lat), 64'(N));
        last_r = er;
        @(posedge clk); #1;
    endtask

    initial begin
        int c1, c2, d0;
        reset = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {27'd0, busy, done, cout, overflow, result}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("add_wrap",  OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        run_op("sub_neg",   OP_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("add_ovf",   OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_ovf",   OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op("add_plain", OP_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);
        run_op("add_chunk", OP_ADD, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);
        run_op("sub_zero",  OP_SUB, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        run_op("sub_min",   OP_SUB, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        run_op("add_negs",  OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);

        // Inputs and start toggled during RUN must be ignored.
        d0 = done_cnt;
        op = OP_ADD; a = 32'd1; b = 32'd2; start = 1'b1;
        sbq.push_back('{32'd3, 1'b0, 1'b0});
        @(posedge clk); #1;
        a = 32'h0000_FFFF; b = 32'h0000_FFFF;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("ignore_dones", 64'(done_cnt - d0), 64'd1);
        chk("ignore_idle",  64'(busy), 64'd0);
        chk("ignore_sb",    64'(sbq.size()), 64'd0);

        // Reset in the second RUN cycle aborts the operation.
        op = OP_ADD; a = 32'h10; b = 32'h20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_outs", {27'd0, busy, done, cout, overflow, result}, 64'd0);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_nodone", 64'(done_cnt - d0), 64'd0);
        last_r = '0;

        // Start held through DONE: second op accepted without a bubble.
        op = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
        sbq.push_back('{32'd2, 1'b0, 1'b0});
        @(posedge clk); #1;
        op = OP_SUB; a = 32'd10; b = 32'd3;
        sbq.push_back('{32'd7, 1'b1, 1'b0});
        wait_done(c1);
        chk("b2b_lat1", 64'(c1), 64'(N));
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done(c2);
        chk("b2b_gap", 64'(1 + c2), 64'(N + 1));
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_sb", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, meaning bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-006 SHALL have port op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-007 SHALL have ports a, b  input  WIDTH  operands; sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port result  output  WIDTH  sum/difference, two's complement.
REQ-011 SHALL have port cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-012 SHALL have port overflow  output  1  signed overflow.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-014 IDLE/DONE with start=1 at an edge: latch a, b XOR {WIDTH{op}}, carry register = op, chunk index = 0; go to RUN.
REQ-015 RUN: each edge adds chunk[index] of both latched operands plus carry register, writes the CHUNK-bit sum into the result shift/accumulate register, updates the carry register, increments the index.
REQ-016 After the edge processing chunk N-1: go to DONE; drive result, cout = final carry, overflow = carry-into-MSB XOR carry-out-of-MSB.
REQ-017 Latency: done SHALL be high in the cycle following exactly N edges after the edge that accepted start; busy high in the cycles between.
REQ-018 DONE lasts one cycle, then IDLE unless start=1 (REQ-014 applies, back-to-back accepted with no bubble).
REQ-019 start while in RUN SHALL be ignored; a, b, op changes during RUN SHALL NOT affect the result.
REQ-020 result, cout, overflow SHALL hold their last completed values until the next completion; they SHALL NOT show partial sums.
REQ-021 CHUNK = WIDTH (N=1) SHALL be supported: done one cycle after the accepting edge.
REQ-022 Arithmetic modulo 2^WIDTH; no saturation.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE, busy=0, done=0, result=0, cout=0, overflow=0, clear carry and index; reset overrides start.
REQ-024 reset during RUN SHALL abort the operation; no done pulse SHALL follow.

Structure
REQ-025 State encodings and op encodings (OP_ADD=0, OP_SUB=1) SHALL live in shared package alu_pkg.
REQ-026 One sub-module chunk_adder (CHUNK-bit ripple of the existing fadder cell, exposing carry into its MSB) SHALL be instantiated once; the FSM, index counter and registers reside in serial_addsub.

Verification (WIDTH=32, CHUNK=8, N=4)
REQ-027 add 0xFFFFFFFF+0x00000001 -> result 0x00000000, cout 1, overflow 0, done 4 cycles after start edge.
REQ-028 sub 0x00000005-0x00000007 -> result 0xFFFFFFFE, cout 0, overflow 0.
REQ-029 add 0x7FFFFFFF+0x00000001 -> 0x80000000, overflow 1, cout 0; sub 0x80000000-0x00000001 -> 0x7FFFFFFF, overflow 1, cout 1.
REQ-030 start with a=1,b=2; during RUN drive a=0xFFFF, b=0xFFFF, start=1 -> single done, result 0x00000003, no second operation.
REQ-031 reset asserted on 2nd RUN cycle -> all outputs 0 next cycle, no done within 10 cycles.
REQ-032 start held high across DONE -> second operation accepted in DONE cycle, second done exactly 5 cycles after the first.
